seg7_io_responder: RTL and testbench
====================================

Name: seg7_io_responder

Overview:
- Memory-mapped 7-segment display peripheral on the I/O bus; bus-side responder for the CPU's two display chip selects.
- Hex select (address 0xFFFF_F830) latches a 32-bit word and shows it as 8 hex digits.
- Decimal select (address 0xFFFF_F840) latches a word and shows it in decimal, after a sequential binary-to-BCD conversion.
- Drives time-multiplexed anode/segment lines of the 8-digit board display.

Parameters:
- SCAN_DIV, 100000: clk cycles each digit is lit before advancing; must be >= 2.
- NDIG, 8: number of display digits; fixed at 8 for this design.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- io_write  in  1  I/O write strobe from controller
- seg_ctrl16  in  1  hex-display chip select
- seg_ctrl10  in  1  decimal-display chip select
- wdata  in  32  write data from bus
- seg_an  out  8  digit anodes, active-low one-hot; bit i = digit i, digit 0 rightmost
- seg_out  out  8  segments, active-low, order {dp,g,f,e,d,c,b,a}
- busy  out  1  high while decimal conversion is in progress

Behaviour:
- Write accept:
  - hex_wr = io_write & seg_ctrl16; dec_wr = io_write & seg_ctrl10; evaluated on rising clk.
  - If both selects are high in the same cycle, hex wins and dec_wr is ignored.
- Hex write:
  - Next edge: disp_nib[7:0] = wdata nibbles, blank mask = 0, mode = HEX.
  - Any conversion in progress is aborted and busy clears.
  - Visible on the next scan of each digit.
- Decimal write uses FSM states IDLE, CONV, DONE.
  - IDLE --dec_wr--> CONV:
    - Load shift = wdata, bcd = 0 (40 bits, 10 digits), cnt = 0, busy = 1.
  - CONV (one double-dabble step per cycle, 32 cycles):
    - Each BCD digit >= 5 gets +3.
    - Then {bcd,shift} shifts left 1 and cnt increments.
    - After the step with cnt = 31, go to DONE.
  - DONE (1 cycle):
    - disp_nib = low 8 BCD digits, i.e. value mod 10^8.
    - Leading-zero digits blanked; digit 0 never blanked.
    - mode = DEC, busy = 0, return to IDLE.
  - Latency: dec_wr at edge N gives new display registers and busy = 0 after edge N+33.
  - The display keeps its old contents until DONE; no partial values are ever shown.
- dec_wr while in CONV or DONE restarts the conversion with the new wdata (latest write wins).
- Writes with io_write = 0, or with neither select high, have no effect.
- Scan:
  - div counter counts 0..SCAN_DIV-1; at SCAN_DIV-1 it wraps to 0 and digit index advances 0→1→…→7→0.
  - seg_an = ~(1<<idx); seg_out = decoded disp_nib[idx], or 0xFF if that digit is blanked.
  - Both outputs are registered: one cycle after idx/data change.
  - dp is always off (bit 7 = 1).
- Decode (active-low): 0:C0, 1:F9, 2:A4, 3:B0, 4:99, 5:92, 6:82, 7:F8, 8:80, 9:90, A:88, b:83, C:C6, d:A1, E:86, F:8E.
- Reset state (synchronous, any state incl. mid-conversion):
  - FSM = IDLE, busy = 0, all counters = 0, idx = 0.
  - disp_nib = 0, blank mask = 0, mode = HEX.
  - seg_an = 8'hFE, seg_out = 8'hC0 (shows 00000000).
  - Any in-flight conversion is discarded.

Test Plan:
- Reset then idle, SCAN_DIV=4 → seg_an steps FE,FD,FB,…,7F every 4 cycles and wraps to FE; seg_out = C0 on every digit; busy = 0.
- Hex write 0x1234ABCD → digit 0..7 seg_out = A1,C6,83,88,99,B0,A4,F9; takes effect the cycle after the write.
- Decimal write 305 (0x131) → busy high exactly 33 cycles; then digits 0..2 = 92,C0,B0, digits 3..7 = FF; old display stable until busy falls.
- Decimal write 0xFFFFFFFF (4294967295) → shows 94967295 on all 8 digits, no blanking.
- Decimal write 7, then decimal write 42 at cycle 10 of CONV → 7 never displayed; 42 appears 33 cycles after the second write.
- Hex write 0xF during CONV → busy drops next cycle, digit 0 = 8E; assert rst mid-CONV → busy = 0, display returns to 00000000.

Source files
------------

// File: rtl/seg7_io_responder_if.sv
// Display chip-select write bus between the I/O controller
// and the seven-segment responder.
interface seg7_io_responder_if;
    logic        io_write;
    logic        seg_ctrl16;
    logic        seg_ctrl10;
    logic [31:0] wdata;

    modport master (
        output io_write,
        output seg_ctrl16,
        output seg_ctrl10,
        output wdata
    );

    modport slave (
        input io_write,
        input seg_ctrl16,
        input seg_ctrl10,
        input wdata
    );
endinterface

// File: rtl/seg7_io_responder.sv
// Eight-digit multiplexed 7-segment display responder with
// hex latch and sequential double-dabble decimal conversion.
module seg7_io_responder #(
    parameter int SCAN_DIV = 100000,
    parameter int NDIG     = 8
) (
    input  logic                clk,
    input  logic                rst,
    seg7_io_responder_if.slave  bus,
    output logic [7:0]          seg_an,
    output logic [7:0]          seg_out,
    output logic                busy
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = $clog2(NDIG);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t             state;
    state_t             state_n;
    logic               hex_wr;
    logic               dec_wr;
    logic               step;
    logic               commit;
    logic [31:0]        shift;
    logic [39:0]        bcd;
    logic [39:0]        bcd_adj;
    logic [4:0]         cnt;
    logic [31:0]        disp_nib;
    logic [NDIG-1:0]    blank;
    logic [NDIG-1:0]    blank_n;
    logic               seen;
    logic               mode_dec;
    logic [DIV_W-1:0]   div;
    logic [IDX_W-1:0]   idx;

    // Hex select has priority when both selects fire together.
    assign hex_wr = bus.io_write & bus.seg_ctrl16;
    assign dec_wr = bus.io_write & bus.seg_ctrl10 & ~hex_wr;

    function automatic logic [7:0] dec7(input logic [3:0] n);
        logic [7:0] s;
        unique case (n)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            4'hF: s = 8'h8E;
        endcase
        return s;
    endfunction

    // Conversion FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state; a new write overrides whatever is in flight.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (dec_wr) state_n = CONV;
            CONV:    if (cnt == 5'd31) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (hex_wr) begin
            state_n = IDLE;
        end else if (dec_wr) begin
            state_n = CONV;
        end
    end

    // FSM outputs: busy flag and datapath step/commit strobes.
    always_comb begin
        busy   = (state != IDLE);
        step   = (state == CONV) & ~hex_wr & ~dec_wr;
        commit = (state == DONE) & ~hex_wr & ~dec_wr;
    end

    // Add-3 correction on every BCD digit before the shift.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 10; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Leading-zero mask: blank digits above the top non-zero one.
    always_comb begin
        blank_n = '0;
        seen    = 1'b0;
        for (int i = NDIG - 1; i > 0; i--) begin
            seen       = seen | (bcd[4*i +: 4] != 4'd0);
            blank_n[i] = ~seen;
        end
    end

    // Conversion datapath and display registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift    <= '0;
            bcd      <= '0;
            cnt      <= '0;
            disp_nib <= '0;
            blank    <= '0;
            mode_dec <= 1'b0;
        end else if (hex_wr) begin
            disp_nib <= bus.wdata;
            blank    <= '0;
            mode_dec <= 1'b0;
        end else if (dec_wr) begin
            shift <= bus.wdata;
            bcd   <= '0;
            cnt   <= '0;
        end else if (step) begin
            bcd   <= {bcd_adj[38:0], shift[31]};
            shift <= {shift[30:0], 1'b0};
            cnt   <= cnt + 5'd1;
        end else if (commit) begin
            disp_nib <= bcd[31:0];
            blank    <= blank_n;
            mode_dec <= 1'b1;
        end
    end

    // Digit scan: hold each digit SCAN_DIV cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            div <= '0;
            idx <= '0;
        end else if (div == DIV_W'(SCAN_DIV - 1)) begin
            div <= '0;
            idx <= idx + 1'b1;
        end else begin
            div <= div + 1'b1;
        end
    end

    // Registered anode and segment drive for the current digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_an  <= 8'hFE;
            seg_out <= 8'hC0;
        end else begin
            seg_an <= ~(8'd1 << idx);
            if (mode_dec && blank[idx]) begin
                seg_out <= 8'hFF;
            end else begin
                seg_out <= dec7(disp_nib[4*idx +: 4]);
            end
        end
    end

endmodule

// File: tb/tb_seg7_io_responder.sv
// Directed bench for seg7_io_responder with a cycle-level
// arithmetic display model and literal digit checks.
module tb_seg7_io_responder;

    localparam int SD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] seg_an;
    logic [7:0] seg_out;
    logic       busy;

    seg7_io_responder_if bif();

    seg7_io_responder #(.SCAN_DIV(SD), .NDIG(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bif),
        .seg_an  (seg_an),
        .seg_out (seg_out),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    logic [7:0] seg_tab [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };
    logic [7:0] an_tab [8] = '{
        8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F
    };

    // Model state: shown value, its radix, pending conversion.
    longint unsigned m_val;
    longint unsigned m_pval;
    bit              m_dec;
    bit              m_pend;
    int              m_left;
    longint          m_cyc;
    logic [7:0]      m_an;
    logic [7:0]      m_so;
    logic            m_busy;

    function automatic logic [7:0] m_seg(longint unsigned v,
                                         bit dec, int i);
        longint unsigned p;
        int d;
        if (!dec) begin
            d = int'((v >> (4 * i)) & 64'd15);
        end else begin
            v = v % 64'd100000000;
            p = 1;
            for (int k = 0; k < i; k++) p = p * 10;
            if (i > 0 && v < p) return 8'hFF;
            d = int'((v / p) % 10);
        end
        return seg_tab[d];
    endfunction

    // Model: output from pre-edge state, then apply this edge's write.
    always @(posedge clk) begin
        if (rst) begin
            m_cyc  = 0;
            m_val  = 0;
            m_dec  = 0;
            m_pend = 0;
            m_busy = 0;
            m_an   = 8'hFE;
            m_so   = 8'hC0;
        end else begin
            int ix;
            ix   = int'((m_cyc / SD) % 8);
            m_an = an_tab[ix];
            m_so = m_seg(m_val, m_dec, ix);
            m_cyc++;
            if (bif.io_write && bif.seg_ctrl16) begin
                m_val  = bif.wdata;
                m_dec  = 0;
                m_pend = 0;
                m_busy = 0;
            end else if (bif.io_write && bif.seg_ctrl10) begin
                m_pval = bif.wdata;
                m_pend = 1;
                m_left = 33;
                m_busy = 1;
            end else if (m_pend) begin
                m_left--;
                if (m_left == 0) begin
                    m_val  = m_pval;
                    m_dec  = 1;
                    m_pend = 0;
                    m_busy = 0;
                end
            end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            vectors++;
            if (seg_an !== m_an || seg_out !== m_so || busy !== m_busy) begin
                miscompares++;
                $display("FAIL model t=%0t an=%h/%h seg=%h/%h busy=%b/%b",
                         $time, seg_an, m_an, seg_out, m_so, busy, m_busy);
            end
        end
    end

    task automatic chk(string name, int got, int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic wr(bit hex, bit dec, logic [31:0] d);
        bif.io_write   = 1'b1;
        bif.seg_ctrl16 = hex;
        bif.seg_ctrl10 = dec;
        bif.wdata      = d;
        @(negedge clk);
        bif.io_write   = 1'b0;
        bif.seg_ctrl16 = 1'b0;
        bif.seg_ctrl10 = 1'b0;
        bif.wdata      = '0;
    endtask

    task automatic busy_len(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic cap_chk(string name, logic [63:0] exp);
        logic [7:0] cap [8];
        for (int k = 0; k < 8; k++) cap[k] = 8'h00;
        for (int c = 0; c < 34; c++) begin
            @(negedge clk);
            for (int k = 0; k < 8; k++)
                if (seg_an == an_tab[k]) cap[k] = seg_out;
        end
        for (int k = 0; k < 8; k++)
            chk($sformatf("%s_d%0d", name, k), int'(cap[k]),
                int'(exp[8*k +: 8]));
    endtask

    initial begin
        int n;
        int nchg;
        int last;
        logic [7:0] prev;

        rst = 1'b1;
        bif.io_write   = 1'b0;
        bif.seg_ctrl16 = 1'b0;
        bif.seg_ctrl10 = 1'b0;
        bif.wdata      = '0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_an", int'(seg_an), 'hFE);
        chk("rst_seg", int'(seg_out), 'hC0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;

        prev = seg_an;
        nchg = 0;
        last = 0;
        for (int c = 1; c <= 60 && nchg < 8; c++) begin
            @(negedge clk);
            if (seg_an != prev) begin
                chk("scan_an", int'(seg_an), int'(an_tab[(nchg + 1) % 8]));
                if (nchg > 0) chk("scan_gap", c - last, SD);
                last = c;
                nchg++;
                prev = seg_an;
            end
        end
        chk("scan_steps", nchg, 8);
        cap_chk("idle", 64'hC0C0C0C0_C0C0C0C0);

        wr(1, 0, 32'h1234ABCD);
        chk("hex_busy", int'(busy), 0);
        cap_chk("hex", 64'hF9A4B099_8883C6A1);

        wr(0, 1, 32'd305);
        busy_len(n);
        chk("d305_busy", n, 33);
        cap_chk("d305", 64'hFFFFFFFF_FFB0C092);

        wr(0, 1, 32'hFFFFFFFF);
        busy_len(n);
        chk("dmax_busy", n, 33);
        cap_chk("dmax", 64'h90999082_F8A49092);

        wr(0, 1, 32'd7);
        repeat (10) @(negedge clk);
        wr(0, 1, 32'd42);
        busy_len(n);
        chk("d42_busy", n, 33);
        cap_chk("d42", 64'hFFFFFFFF_FFFF99A4);

        wr(1, 1, 32'h5);
        chk("both_busy", int'(busy), 0);
        bif.seg_ctrl10 = 1'b1;
        bif.seg_ctrl16 = 1'b1;
        bif.wdata      = 32'h77;
        @(negedge clk);
        bif.seg_ctrl10 = 1'b0;
        bif.seg_ctrl16 = 1'b0;
        chk("nowr_busy", int'(busy), 0);
        cap_chk("both", 64'hC0C0C0C0_C0C0C092);

        wr(0, 1, 32'd12345);
        repeat (5) @(negedge clk);
        chk("conv_busy", int'(busy), 1);
        wr(1, 0, 32'hF);
        chk("abort_busy", int'(busy), 0);
        cap_chk("abort", 64'hC0C0C0C0_C0C0C08E);

        wr(0, 1, 32'd99999);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_an", int'(seg_an), 'hFE);
        chk("mrst_seg", int'(seg_out), 'hC0);
        cap_chk("mrst", 64'hC0C0C0C0_C0C0C0C0);
        repeat (40) @(negedge clk);
        chk("mrst_late_busy", int'(busy), 0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
